// File: rtl/dtc_rr_scheduler_if.sv
// Bundles the requester, classifier and response signals of dtc_rr_scheduler.
// The scheduler connects through the slave modport; its environment uses master.
interface dtc_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 7,
    parameter int OUT_W   = 10,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [IN_W-1:0]         cls_inp;
    logic [OUT_W-1:0]        cls_outp;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [OUT_W-1:0]        rsp_data;
    logic                    rsp_ready;
    logic                    busy;
    logic [15:0]             rsp_count;

    modport slave (
        input  req_valid, req_data, cls_outp, rsp_ready,
        output req_ready, cls_inp, rsp_valid, rsp_id, rsp_data, busy, rsp_count
    );

    modport master (
        output req_valid, req_data, cls_outp, rsp_ready,
        input  req_ready, cls_inp, rsp_valid, rsp_id, rsp_data, busy, rsp_count
    );
endinterface

// File: rtl/dtc_rr_scheduler.sv
// Round-robin time-sharing of one combinational decision-tree classifier between
// NUM_REQ requesters; one request in flight, result returned with its requester ID.
module dtc_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 7,
    parameter int OUT_W   = 10,
    parameter int CLS_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    dtc_rr_scheduler_if.slave    bus
);

    localparam int              CNT_W    = (CLS_LAT > 1) ? $clog2(CLS_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLS_LAT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [IN_W-1:0]      r_cls_inp;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [OUT_W-1:0]     r_rsp_data;
    logic [15:0]          r_rsp_count;
    logic                 r_busy;

    logic                 w_grant_vld;
    logic [ID_W-1:0]      w_grant_idx;
    logic [ID_W-1:0]      w_cand;
    logic                 w_hit;
    logic [NUM_REQ-1:0]   w_req_ready;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_rsp_done;

    // (base + k) mod NUM_REQ for base < NUM_REQ and k < NUM_REQ
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
        return ID_W'(s);
    endfunction

    // Round-robin search starting at the pointer; first valid lane wins
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_hit       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand      = rr_idx(r_rr_ptr, k);
            w_hit       = ~w_grant_vld & bus.req_valid[w_cand];
            w_grant_idx = w_hit ? w_cand : w_grant_idx;
            w_grant_vld = w_grant_vld | w_hit;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and per-state strobes; req_ready is the only combinational output
    always_comb begin
        w_state_nx  = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        w_req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld && !rst) begin
                    w_req_ready = NUM_REQ'(1) << w_grant_idx;
                    w_accept    = 1'b1;
                    w_state_nx  = ST_WAIT;
                end else begin
                    w_state_nx  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_capture  = 1'b1;
                    w_state_nx = ST_RESP;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_done = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_RESP;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Request capture onto the classifier input and settle countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls_inp  <= '0;
            r_id       <= '0;
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_cls_inp  <= bus.req_data[w_grant_idx*IN_W +: IN_W];
            r_id       <= w_grant_idx;
            r_wait_cnt <= CNT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        end
    end

    // Response channel; the served lane drops to lowest priority on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= bus.cls_outp;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_id == ID_LAST) ? '0 : (r_id + ID_W'(1));
        end
    end

    // Completion counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_count <= 16'd0;
        end else if (w_rsp_done) begin
            r_rsp_count <= r_rsp_count + 16'd1;
        end
    end

    // Busy flag registered from the next state so it tracks state != IDLE exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != ST_IDLE);
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.cls_inp   = r_cls_inp;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_count = r_rsp_count;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_dtc_rr_scheduler.sv
// Self-checking bench for dtc_rr_scheduler: vector table, directed corner cases
// and randomized traffic against a transaction-level reference model.
module tb_dtc_rr_scheduler;
    localparam int NR = 4;
    localparam int IW = 7;
    localparam int OW = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] exp_count;

    dtc_rr_scheduler_if #(.NUM_REQ(NR), .IN_W(IW), .OUT_W(OW)) bus  ();
    dtc_rr_scheduler_if #(.NUM_REQ(NR), .IN_W(IW), .OUT_W(OW)) bus3 ();

    dtc_rr_scheduler #(.NUM_REQ(NR), .IN_W(IW), .OUT_W(OW), .CLS_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    dtc_rr_scheduler #(.NUM_REQ(NR), .IN_W(IW), .OUT_W(OW), .CLS_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    assign bus.cls_outp  = {3'b101, bus.cls_inp};
    assign bus3.cls_outp = {3'b101, bus3.cls_inp};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [27:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [9:0]  exp_rsp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 16'd0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_data  = v.data;
        bus.rsp_ready = 1'b1;
        #1;
        check("vec_req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
        check("vec_busy_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("vec_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("vec_wait_req_ready", 32'(bus.req_ready), 32'd0);
        check("vec_wait_busy", 32'(bus.busy), 32'd1);
        check("vec_cls_inp", 32'(bus.cls_inp), 32'(v.exp_rsp[6:0]));
        @(negedge clk);
        check("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("vec_rsp_id", 32'(bus.rsp_id), 32'(v.exp_id));
        check("vec_rsp_data", 32'(bus.rsp_data), 32'(v.exp_rsp));
        bus.req_valid = 4'b0000;
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        check("vec_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("vec_done_busy", 32'(bus.busy), 32'd0);
        check("vec_rsp_count", 32'(bus.rsp_count), 32'(exp_count));
    endtask

    task automatic run_random(input int ncyc);
        logic [3:0]  vld;
        logic [27:0] data;
        logic [3:0]  exp_rdy;
        bit          m_busy;
        bit          m_out;
        int          m_age;
        int          m_owner;
        int          m_next;
        int          m_rid;
        int          g;
        logic [6:0]  m_feat;
        logic [9:0]  m_rdata;
        logic [15:0] m_cnt;
        vld = 4'b0000; data = 28'd0;
        m_busy = 1'b0; m_out = 1'b0; m_age = 0; m_owner = 0; m_next = 0; m_rid = 0;
        m_feat = 7'd0; m_rdata = 10'd0; m_cnt = 16'd0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (vld[i]) begin
                    if ($urandom_range(0, 7) == 0) vld[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    vld[i] = 1'b1;
                    data[i*IW +: IW] = 7'($urandom);
                end
            end
            bus.req_valid = vld;
            bus.req_data  = data;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    if (g < 0 && vld[(m_next + k) % NR]) g = (m_next + k) % NR;
                end
            end
            exp_rdy = 4'b0000;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("rand_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            check("rand_rsp_valid", 32'(bus.rsp_valid), 32'(m_out));
            check("rand_busy", 32'(bus.busy), 32'(m_busy));
            check("rand_rsp_count", 32'(bus.rsp_count), 32'(m_cnt));
            if (m_out) begin
                check("rand_rsp_id", 32'(bus.rsp_id), 32'(m_rid));
                check("rand_rsp_data", 32'(bus.rsp_data), 32'(m_rdata));
            end
            if (m_busy) check("rand_cls_inp", 32'(bus.cls_inp), 32'(m_feat));
            if (g >= 0) begin
                m_busy = 1'b1; m_out = 1'b0; m_age = 0; m_owner = g;
                m_feat = data[g*IW +: IW];
            end else if (m_busy && !m_out) begin
                m_age++;
                if (m_age >= 1) begin
                    m_out = 1'b1; m_rid = m_owner; m_rdata = {3'b101, m_feat};
                end
            end else if (m_out && bus.rsp_ready) begin
                m_out = 1'b0; m_busy = 1'b0; m_cnt = m_cnt + 16'd1;
                m_next = (m_owner + 1) % NR;
            end
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc_cyc [$];
        logic [1:0] rids [$];
        logic [9:0] rdat [$];

        vecs[0] = '{4'b0100, {7'h00, 7'h15, 7'h00, 7'h00}, 4'b0100, 2'd2, 10'h295};
        vecs[1] = '{4'b0011, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0001, 2'd0, 10'h291};
        vecs[2] = '{4'b1001, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b1000, 2'd3, 10'h2C4};
        vecs[3] = '{4'b1111, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0001, 2'd0, 10'h291};
        vecs[4] = '{4'b0001, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0001, 2'd0, 10'h291};
        vecs[5] = '{4'b0110, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b0010, 2'd1, 10'h2A2};
        vecs[6] = '{4'b1010, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b1000, 2'd3, 10'h2C4};

        rst = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_data   = 28'd0;
        bus.rsp_ready  = 1'b0;
        bus3.req_valid = 4'b0000;
        bus3.req_data  = 28'd0;
        bus3.rsp_ready = 1'b0;
        exp_count = 16'd0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
        check("rst_cls_inp", 32'(bus.cls_inp), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 4'b0000;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Round-robin with all lanes valid
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b1111;
        bus.req_data  = {7'd3, 7'd2, 7'd1, 7'd0};
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && rids.size() < 5; c++) begin
            #1;
            if (bus.req_ready != 4'b0000) acc_cyc.push_back(c);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rids.push_back(bus.rsp_id);
                rdat.push_back(bus.rsp_data);
            end
            @(negedge clk);
        end
        bus.req_valid = 4'b0000;
        check("rr_num_responses", 32'(rids.size()), 32'd5);
        for (int i = 0; i < rids.size(); i++) begin
            check("rr_order", 32'(rids[i]), 32'(i % NR));
            check("rr_data", 32'(rdat[i]), 32'({3'b101, 7'(i % NR)}));
        end
        check("rr_num_accepts", 32'(acc_cyc.size() >= 5), 32'd1);
        for (int i = 1; i < acc_cyc.size() && i < 5; i++)
            check("rr_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

        // Back-pressure
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_data  = {7'h00, 7'h00, 7'h5A, 7'h00};
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            check("bp_rsp_data", 32'(bus.rsp_data), 32'h2DA);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_release_count", 32'(bus.rsp_count), 32'd1);
        repeat (5) @(negedge clk);
        check("bp_single_handshake", 32'(bus.rsp_count), 32'd1);
        check("bp_next_rsp_id", 32'(bus.rsp_id), 32'd2);
        check("bp_next_rsp_valid", 32'(bus.rsp_valid), 32'd1);

        // Reset while in WAIT
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_data  = {7'h00, 7'h2B, 7'h00, 7'h00};
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        check("mid_rsp_count", 32'(bus.rsp_count), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 4'b1111;
        #1;
        check("mid_first_grant", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (3) @(negedge clk);

        // Completion counter wrap
        do_reset();
        @(negedge clk);
        force u_dut.r_rsp_count = 16'hFFFF;
        #1;
        release u_dut.r_rsp_count;
        @(negedge clk);
        check("wrap_preload", 32'(bus.rsp_count), 32'hFFFF);
        exp_count = 16'hFFFF;
        run_vec('{4'b1000, {7'h44, 7'h33, 7'h22, 7'h11}, 4'b1000, 2'd3, 10'h2C4});
        check("wrap_zero", 32'(bus.rsp_count), 32'd0);

        // CLS_LAT = 3 instance
        @(negedge clk);
        bus3.req_valid = 4'b0010;
        bus3.req_data  = {7'h00, 7'h00, 7'h7F, 7'h00};
        bus3.rsp_ready = 1'b1;
        #1;
        check("lat3_req_ready", 32'(bus3.req_ready), 32'b0010);
        @(posedge clk);
        #1;
        bus3.req_valid = 4'b0000;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            check("lat3_rsp_valid", 32'(bus3.rsp_valid), 32'(e == 4));
            check("lat3_cls_inp", 32'(bus3.cls_inp), 32'h7F);
            check("lat3_busy", 32'(bus3.busy), 32'd1);
        end
        check("lat3_rsp_data", 32'(bus3.rsp_data), 32'h2FF);
        check("lat3_rsp_id", 32'(bus3.rsp_id), 32'd1);
        @(negedge clk);
        check("lat3_done_valid", 32'(bus3.rsp_valid), 32'd0);
        check("lat3_done_busy", 32'(bus3.busy), 32'd0);
        check("lat3_count", 32'(bus3.rsp_count), 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        run_random(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dtc_rr_scheduler.md
Name: dtc_rr_scheduler

Overview:
- Time-shares one combinational decision-tree classifier instance (IN_W-bit feature vector in, OUT_W-bit class code out) between NUM_REQ requesters.
- Selects requesters round-robin, registers the chosen feature vector onto the classifier input and waits a fixed settle time.
- Captures the class code and returns it on a single response channel, tagged with the requester ID.
- Sits between feature-producing front ends and the generated classifier netlist.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥ 2.
- IN_W, 7, feature vector width.
- OUT_W, 10, class code width.
- CLS_LAT, 1, cycles from the registered classifier input to capture of the classifier output; must be ≥ 1.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*IN_W  feature vectors; requester i uses bits [i*IN_W +: IN_W].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- cls_inp  out  IN_W  registered feature vector driven to the classifier.
- cls_outp  in  OUT_W  classifier result (combinational function of cls_inp).
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  OUT_W  captured class code.
- rsp_ready  in  1  response consumer accept.
- busy  out  1  high whenever state ≠ IDLE.
- rsp_count  out  16  completed responses; wraps 0xFFFF→0.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - cls_inp=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_count=0.
  - req_ready=0 during the reset cycle.
  - Reset mid-operation abandons the in-flight request: no response is issued and the accepted data is dropped.
- IDLE:
  - grant = first index g with req_valid[g]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready is combinational: one-hot at grant when any req_valid is high, otherwise all zero. Only in IDLE; all zero in WAIT and RESP.
  - Handshake fires when req_valid[g] & req_ready[g]. At that edge: cls_inp<=req_data slice g, id reg<=g, wait counter<=CLS_LAT-1, state<=WAIT.
  - No request pending: stay in IDLE, registers hold.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter equals 0: rsp_data<=cls_outp, rsp_id<=id reg, rsp_valid<=1, state<=RESP.
  - WAIT therefore lasts exactly CLS_LAT cycles.
  - cls_inp is held stable throughout WAIT and RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid & rsp_ready.
  - At the handshake edge: rsp_valid<=0, rsp_count<=rsp_count+1 (mod 2^16), rr_ptr<=(id reg+1) mod NUM_REQ, state<=IDLE.
  - Back-pressure (rsp_ready=0) stalls indefinitely with no loss.
- Latency and throughput:
  - Request accept to rsp_valid = CLS_LAT+1 edges.
  - One outstanding request at a time.
  - Minimum issue interval is CLS_LAT+2 cycles when rsp_ready is tied high.
- Fairness:
  - The most recently served requester has lowest priority next round.
  - With all requesters valid continuously, service order is 0,1,…,NUM_REQ-1,0,…
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Requesters may deassert req_valid before being granted. The scheduler samples only in IDLE, so no request is accepted unless it is valid in that IDLE cycle.
- A requester that has not been granted keeps its req_data stable while req_valid is high.

Test Plan:
Bench classifier model for all scenarios: cls_outp = {3'b101, cls_inp}. Defaults: NUM_REQ=4, CLS_LAT=1.
- Reset and single request: after reset all outputs are 0. req_valid=4'b0100, lane 2 data=7'h15 → req_ready=4'b0100 for one cycle; 2 edges later rsp_valid=1, rsp_id=2, rsp_data=10'h295; with rsp_ready=1 then rsp_count=1.
- Round-robin fairness: all four lanes valid continuously, lane i data=i, rsp_ready=1 → responses in id order 0,1,2,3,0. rsp_data for id 3 = 10'h283. Each new accept comes 3 cycles after the previous one.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid rises → rsp_valid, rsp_id and rsp_data stay constant, req_ready=0, busy=1. When rsp_ready=1, exactly one handshake occurs and rsp_count increments by 1.
- CLS_LAT=3 build: accept lane 1 data=7'h7F → rsp_valid rises exactly 4 edges after accept, rsp_data=10'h2FF. cls_inp=7'h7F from the accept edge until return to IDLE.
- Reset mid-operation: assert rst for 1 cycle while in WAIT, then hold req_valid low → no rsp_valid ever rises, rsp_count=0, rr_ptr=0; the next grant for all-valid is lane 0.
- Counter wrap: preload 65535 completions (or force rsp_count=16'hFFFF), then complete one more → rsp_count=0.
